mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 2000, meaning the maximum number of cycles to wait for mul_busy low (used only with MUL_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester N holds its request until granted.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  8 each  operands of requester N.
REQ-006 gnt0, gnt1  output  1 each  one-cycle pulse; request N accepted and operands latched.
REQ-007 resp0_valid, resp1_valid  output  1 each  one-cycle pulse; result for requester N valid.
REQ-008 resp_result  output  16  product of the completed request; valid while any resp*_valid is high.
REQ-009 resp_err  output  1  timeout flag; valid while any resp*_valid is high.
REQ-010 mul_a, mul_b  output  8 each  operands to the shared multiplier; held stable from START through completion.
REQ-011 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-012 mul_rst  output  1  active-high multiplier reset.
REQ-013 mul_result  input  16; mul_busy  input  1  multiplier outputs.

Function
REQ-014 The FSM SHALL have states IDLE, START, ARM and WAIT; all outputs except mul_rst are registered.
REQ-015 In IDLE, at an edge with any request pending, the block SHALL latch the winner's operands into mul_a/mul_b, record the owner, pulse gnt<owner> for the following cycle, and go to START.
REQ-016 Arbitration SHALL be round-robin: if both requests are present, the requester not granted last wins; after reset, requester 0 has priority.
REQ-017 If only one request is present, it SHALL win regardless of pointer; the pointer updates to the winner on every grant.
REQ-018 In START, mul_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to ARM.
REQ-019 ARM SHALL last exactly one cycle without sampling mul_busy, then the FSM SHALL go to WAIT.
REQ-020 In WAIT, at the first edge with mul_busy=0, the block SHALL register resp_result=mul_result, resp_err=0, pulse resp<owner>_valid for one cycle, and return to IDLE.
REQ-021 The block SHALL accept no new grant in the same cycle as a response; minimum spacing between grants is 5 cycles.
REQ-022 A request arriving or deasserting during START/ARM/WAIT SHALL be ignored until IDLE; the requester must hold req*_valid until it sees gnt.
REQ-023 resp_result and resp_err SHALL hold their last values between responses.

Reset
REQ-024 While rst=0, the block SHALL asynchronously force state IDLE, pointer to requester 0, and gnt*, resp*_valid, resp_err, mul_start to 0; resp_result, mul_a and mul_b to 0.
REQ-025 mul_rst SHALL equal (~rst) OR the timeout abort pulse, so a reset mid-operation also resets the multiplier; the in-flight request SHALL be discarded with no response.

Configuration
REQ-026 With macro MUL_ARB_TIMEOUT_EN defined, a counter SHALL run in ARM and WAIT. If it reaches TIMEOUT_CYCLES with mul_busy still 1, the block SHALL pulse resp<owner>_valid with resp_err=1 and resp_result=0, assert mul_rst for one cycle, and return to IDLE.
REQ-027 Without MUL_ARB_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL wait indefinitely, resp_err SHALL be tied 0, and mul_rst SHALL equal ~rst.

Verification
REQ-028 A single request, req0 with 3*2, SHALL produce gnt0, one mul_start pulse, then resp0_valid with resp_result=6 and resp_err=0.
REQ-029 Simultaneous requests after reset, req0 with 5*5 and req1 with 4*3, SHALL grant port 0 first (result 25), then port 1 (result 12), with no overlap of mul_start.
REQ-030 Both ports requesting continuously for 6 transactions SHALL produce grants alternating 0,1,0,1,0,1, with no port starved.
REQ-031 rst pulled low during WAIT of a 255*255 operation SHALL immediately clear all outputs and hold mul_rst high with no response; a subsequent 1*1 SHALL return 1.
REQ-032 With MUL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20, a stub holding mul_busy=1 SHALL produce resp_valid with resp_err=1 and resp_result=0 after 20 cycles, plus a one-cycle mul_rst pulse.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// mul_arbiter_if
// Bundles the two requester ports, the shared response bus and the link to the
// shared 8x8 multiplier used by mul_arbiter.
//   slave  : the arbiter side (takes requests, drives grants/responses and
//            the multiplier operands/controls)
//   master : the environment side (requesters plus the multiplier itself)
// Signals:
//   req0_valid/req1_valid, req*_a/req*_b : requests and 8-bit operands
//   gnt0/gnt1                           : one-cycle grant pulses
//   resp0_valid/resp1_valid             : one-cycle response pulses
//   resp_result[15:0], resp_err         : response payload (held between pulses)
//   mul_a/mul_b, mul_start, mul_rst     : multiplier operands and controls
//   mul_result[15:0], mul_busy          : multiplier outputs
// -----------------------------------------------------------------------------
interface mul_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        gnt0;
  logic        gnt1;
  logic        resp0_valid;
  logic        resp1_valid;
  logic [15:0] resp_result;
  logic        resp_err;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_start;
  logic        mul_rst;
  logic [15:0] mul_result;
  logic        mul_busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  mul_result, mul_busy,
    output gnt0, gnt1, resp0_valid, resp1_valid, resp_result, resp_err,
    output mul_a, mul_b, mul_start, mul_rst
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output mul_result, mul_busy,
    input  gnt0, gnt1, resp0_valid, resp1_valid, resp_result, resp_err,
    input  mul_a, mul_b, mul_start, mul_rst
  );
endinterface

// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
// Round-robin arbiter sharing one multiplier between two requesters.
// A request is granted in IDLE, the multiplier is started (START), given one
// settling cycle (ARM) and then polled until mul_busy drops (WAIT); the result
// is returned to the owner as a one-cycle response pulse.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mul_arbiter_if.slave (requests, grants, responses, multiplier link)
// Parameter:
//   TIMEOUT_CYCLES : ARM+WAIT cycle budget before aborting a busy multiplier
// Optional feature macro:
//   MUL_ARB_TIMEOUT_EN : enables the timeout counter, resp_err and the
//                        one-cycle mul_rst abort pulse.
// -----------------------------------------------------------------------------
module mul_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd2000
) (
  input  logic          clk,
  input  logic          rst,
  mul_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_ARM   = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ptr;        // last winner
  logic        r_seen;       // a grant has happened since reset
  logic        r_owner;      // owner of the in-flight operation
  logic        r_gnt0, r_gnt1, r_resp0, r_resp1, r_start;
  logic [15:0] r_result;
  logic [7:0]  r_mul_a, r_mul_b;

  logic        w_win1, w_grant, w_done, w_tmo, w_resp_pend;
  logic        w_gnt0_nxt, w_gnt1_nxt, w_resp0_nxt, w_resp1_nxt, w_start_nxt;
  logic [15:0] w_result_nxt;
  logic [7:0]  w_mul_a_nxt, w_mul_b_nxt;

  // No grant while a response pulse is on the bus: enforces grant spacing.
  assign w_resp_pend = r_resp0 | r_resp1;
  assign w_grant     = (r_state == S_IDLE) & (bus.req0_valid | bus.req1_valid) & ~w_resp_pend;
  assign w_done      = (r_state == S_WAIT) & ~bus.mul_busy;

  // Winner select: a lone request always wins; on contention the requester not
  // granted last wins, with requester 0 first after reset.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      w_win1 = r_seen ? ~r_ptr : 1'b0;
    end else begin
      w_win1 = bus.req1_valid;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_abort;

  // Counter value includes the current cycle, so the abort fires on the
  // TIMEOUT_CYCLES-th ARM/WAIT cycle.
  assign w_tmo = (r_state == S_WAIT) & bus.mul_busy & (r_cnt >= CNT_LAST);

  // Timeout counter: cleared on grant, counts every ARM and WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_grant) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == S_ARM) || (r_state == S_WAIT)) begin
      r_cnt <= r_cnt + CNT_W'(1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Error flag (held between responses) and one-cycle multiplier abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_tmo;
      if (w_tmo) begin
        r_err <= 1'b1;
      end else if (w_done) begin
        r_err <= 1'b0;
      end else begin
        r_err <= r_err;
      end
    end
  end

  assign bus.resp_err = r_err;
  assign bus.mul_rst  = ~rst | r_abort;
`else
  logic [31:0] w_unused_cfg;

  assign w_unused_cfg = TIMEOUT_CYCLES;
  assign w_tmo        = 1'b0;
  assign bus.resp_err = 1'b0;
  assign bus.mul_rst  = ~rst;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_grant ? S_START : S_IDLE;
      S_START: w_state_nxt = S_ARM;
      S_ARM:   w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = (w_done || w_tmo) ? S_IDLE : S_WAIT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_gnt0_nxt   = w_grant & ~w_win1;
    w_gnt1_nxt   = w_grant & w_win1;
    w_start_nxt  = w_grant;
    w_resp0_nxt  = (w_done | w_tmo) & ~r_owner;
    w_resp1_nxt  = (w_done | w_tmo) & r_owner;
    if (w_done) begin
      w_result_nxt = bus.mul_result;
    end else if (w_tmo) begin
      w_result_nxt = 16'h0000;
    end else begin
      w_result_nxt = r_result;
    end
    if (w_grant) begin
      w_mul_a_nxt = w_win1 ? bus.req1_a : bus.req0_a;
      w_mul_b_nxt = w_win1 ? bus.req1_b : bus.req0_b;
    end else begin
      w_mul_a_nxt = r_mul_a;
      w_mul_b_nxt = r_mul_b;
    end
  end

  // Output, ownership and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_resp0  <= 1'b0;
      r_resp1  <= 1'b0;
      r_start  <= 1'b0;
      r_result <= 16'h0000;
      r_mul_a  <= 8'h00;
      r_mul_b  <= 8'h00;
      r_ptr    <= 1'b0;
      r_seen   <= 1'b0;
      r_owner  <= 1'b0;
    end else begin
      r_gnt0   <= w_gnt0_nxt;
      r_gnt1   <= w_gnt1_nxt;
      r_resp0  <= w_resp0_nxt;
      r_resp1  <= w_resp1_nxt;
      r_start  <= w_start_nxt;
      r_result <= w_result_nxt;
      r_mul_a  <= w_mul_a_nxt;
      r_mul_b  <= w_mul_b_nxt;
      if (w_grant) begin
        r_ptr   <= w_win1;
        r_owner <= w_win1;
        r_seen  <= 1'b1;
      end else begin
        r_ptr   <= r_ptr;
        r_owner <= r_owner;
        r_seen  <= r_seen;
      end
    end
  end

  assign bus.gnt0        = r_gnt0;
  assign bus.gnt1        = r_gnt1;
  assign bus.resp0_valid = r_resp0;
  assign bus.resp1_valid = r_resp1;
  assign bus.resp_result = r_result;
  assign bus.mul_a       = r_mul_a;
  assign bus.mul_b       = r_mul_b;
  assign bus.mul_start   = r_start;

endmodule

// File: tb/tb_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_arbiter
// Scoreboard bench for mul_arbiter. Requests push their hand-computed expected
// responses (and the expected grant order) into queues; a monitor running on
// the falling edge pops and compares whenever the DUT shows a grant or a
// response. A behavioural multiplier stub answers after LAT cycles, or holds
// mul_busy high forever when stub_hang is set.
// -----------------------------------------------------------------------------
module tb_mul_arbiter;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 2000;
`endif
  localparam int LAT = 3;

  typedef struct packed {
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic stub_hang;
  logic [15:0] stub_prod;
  int   stub_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_gnt = -1000;
  int   gnt_cyc  = 0;
  int   outstanding = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   gq[$];

  mul_arbiter_if bus ();

  mul_arbiter #(.TIMEOUT_CYCLES(TMO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: busy for LAT cycles after a start pulse.
  always @(posedge clk) begin
    if (bus.mul_rst) begin
      bus.mul_busy <= 1'b0;
      stub_cnt     <= 0;
    end else if (bus.mul_start) begin
      bus.mul_busy <= 1'b1;
      stub_prod    <= bus.mul_a * bus.mul_b;
      stub_cnt     <= LAT;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end else if (stub_cnt == 1 && !stub_hang) begin
      bus.mul_busy   <= 1'b0;
      bus.mul_result <= stub_prod;
      stub_cnt       <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Compare one response against the head of the owner's queue.
  task automatic pop_resp(input int port);
    exp_t e;
    if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
      fail_now(port == 0 ? "resp0_unexpected" : "resp1_unexpected");
    end else begin
      e = (port == 0) ? q0.pop_front() : q1.pop_front();
      check(port == 0 ? "resp0_result" : "resp1_result", {16'h0, bus.resp_result}, {16'h0, e.res});
      check("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
      check("mul_rst_at_resp", {31'h0, bus.mul_rst}, {31'h0, e.err});
      // Normal: gnt at E0, stub busy E1..E(1+LAT), done edge E(2+LAT).
      // Timeout: abort on the TMO-th ARM/WAIT cycle, edge E(TMO+1).
      check("resp_latency", cyc - gnt_cyc, e.err ? TMO + 1 : LAT + 2);
    end
  endtask

  // Monitor / scoreboard consumer.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        outstanding = 0;
        last_gnt    = -1000;
      end else begin
        if (bus.gnt0 || bus.gnt1) begin
          check("gnt_onehot", {31'h0, bus.gnt0 & bus.gnt1}, 32'd0);
          check("gnt_with_start", {31'h0, bus.mul_start}, 32'd1);
          check("start_no_overlap", outstanding, 32'd0);
          check("gnt_spacing_ge5", {31'h0, (cyc - last_gnt) >= 5}, 32'd1);
          if (gq.size() == 0) begin
            fail_now("gnt_unexpected");
          end else begin
            check("gnt_order", {31'h0, bus.gnt1}, gq.pop_front());
          end
          outstanding = 1;
          last_gnt    = cyc;
          gnt_cyc     = cyc;
        end else begin
          check("start_without_gnt", {31'h0, bus.mul_start}, 32'd0);
        end
        if (bus.resp0_valid || bus.resp1_valid) begin
          check("resp_onehot", {31'h0, bus.resp0_valid & bus.resp1_valid}, 32'd0);
          pop_resp(bus.resp1_valid ? 1 : 0);
          outstanding = 0;
        end
      end
    end
  end

  // Raise a request, optionally queue its expected response, hold until granted.
  task automatic do_req(input int port, input logic [7:0] a, input logic [7:0] b,
                        input bit push, input logic [15:0] res, input logic err);
    bit got = 1'b0;
    exp_t e;
    e.res = res;
    e.err = err;
    if (port == 0) begin
      if (push) q0.push_back(e);
      bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      if (push) q1.push_back(e);
      bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((port == 0) ? bus.gnt0 : bus.gnt1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now(port == 0 ? "gnt0_timeout" : "gnt1_timeout");
    if (port == 0) bus.req0_valid = 1'b0;
    else           bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 3 * TMO + 100; c++) begin
      if (q0.size() == 0 && q1.size() == 0 && gq.size() == 0) break;
      @(negedge clk);
    end
    check("drain_q0", q0.size(), 32'd0);
    check("drain_q1", q1.size(), 32'd0);
    check("drain_gq", gq.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    stub_hang = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = 8'h00; bus.req0_b = 8'h00; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.gnt0, bus.gnt1, bus.resp0_valid, bus.resp1_valid, bus.resp_err,
                            bus.mul_start, bus.resp_result, bus.mul_a, bus.mul_b}, 32'd0);
    check("reset_mul_rst", {31'h0, bus.mul_rst}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("run_mul_rst", {31'h0, bus.mul_rst}, 32'd0);

    // Single request: 3*2 = 6.
    gq.push_back(0);
    do_req(0, 8'd3, 8'd2, 1'b1, 16'd6, 1'b0);
    drain();

    // Simultaneous after reset: port 0 (25) then port 1 (12).
    pulse_reset();
    gq.push_back(0); gq.push_back(1);
    fork
      do_req(0, 8'd5, 8'd5, 1'b1, 16'd25, 1'b0);
      do_req(1, 8'd4, 8'd3, 1'b1, 16'd12, 1'b0);
    join
    drain();

    // Continuous contention: grants must alternate 0,1,0,1,0,1.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      gq.push_back(0); gq.push_back(1);
    end
    fork
      begin
        do_req(0, 8'd2, 8'd3, 1'b1, 16'd6, 1'b0);
        do_req(0, 8'd10, 8'd10, 1'b1, 16'd100, 1'b0);
        do_req(0, 8'd255, 8'd2, 1'b1, 16'd510, 1'b0);
      end
      begin
        do_req(1, 8'd7, 8'd8, 1'b1, 16'd56, 1'b0);
        do_req(1, 8'd16, 8'd16, 1'b1, 16'd256, 1'b0);
        do_req(1, 8'd255, 8'd255, 1'b1, 16'd65025, 1'b0);
      end
    join
    drain();

    // Reset during WAIT of 255*255: outputs clear, mul_rst high, no response.
    stub_hang = 1'b1;
    gq.push_back(0);
    do_req(0, 8'd255, 8'd255, 1'b0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midop_reset_outputs", {bus.gnt0, bus.gnt1, bus.resp0_valid, bus.resp1_valid, bus.resp_err,
                                  bus.mul_start, bus.resp_result, bus.mul_a, bus.mul_b}, 32'd0);
    check("midop_mul_rst", {31'h0, bus.mul_rst}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midop_no_resp", {30'h0, bus.resp0_valid, bus.resp1_valid}, 32'd0);
      check("midop_mul_rst_held", {31'h0, bus.mul_rst}, 32'd1);
    end
    stub_hang = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    gq.push_back(0);
    do_req(0, 8'd1, 8'd1, 1'b1, 16'd1, 1'b0);
    drain();

`ifdef MUL_ARB_TIMEOUT_EN
    // Stuck multiplier: error response with result 0 and a mul_rst pulse.
    stub_hang = 1'b1;
    gq.push_back(0);
    do_req(0, 8'd7, 8'd7, 1'b1, 16'd0, 1'b1);
    drain();
    check("tmo_mul_rst_released", {31'h0, bus.mul_rst}, 32'd0);
    stub_hang = 1'b0;
    gq.push_back(1);
    do_req(1, 8'd9, 8'd9, 1'b1, 16'd81, 1'b0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
